// File: rtl/regfile_dump_pkg.sv
// regfile_dump shared types and default sizes.
// Also used by registerunit and the trace port.
package regfile_dump_pkg;

  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Control, register-file read port and output stream
// of the register-file dump engine.
interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;

  // Dump engine side.
  modport master (
    input  start,
    input  abort,
    input  rf_data,
    input  out_ready,
    output busy,
    output done,
    output rf_addr,
    output out_valid,
    output out_data,
    output out_index
  );

  // Requester / register file / consumer side.
  modport slave (
    output start,
    output abort,
    output rf_data,
    output out_ready,
    input  busy,
    input  done,
    input  rf_addr,
    input  out_valid,
    input  out_data,
    input  out_index
  );

endinterface

// File: rtl/regfile_dump.sv
// Walks register indices 0..NREGS-1 through one read port
// and streams each captured value out tagged with its index.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  regfile_dump_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oidx_q, oidx_d;
  logic              hs;
  logic              last;

  // A word leaves only while it is presented in SEND.
  assign hs   = (state_q == SEND) && bus.out_ready;
  assign last = (idx_q == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) state_d = READ;
        READ: state_d = SEND;
        SEND: if (hs) state_d = last ? DONE : READ;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Index walk and capture of the read port.
  always_comb begin
    idx_d  = idx_q;
    data_d = data_q;
    oidx_d = oidx_q;
    if (bus.abort) begin
      idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: idx_d = '0;
        READ: begin
          data_d = bus.rf_data;
          oidx_d = idx_q;
        end
        SEND: if (hs && !last) idx_d = idx_q + ADDR_W'(1);
        DONE: idx_d = '0;
        default: idx_d = '0;
      endcase
    end
  end

  // Index and output word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
      oidx_q <= '0;
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      oidx_q <= oidx_d;
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    bus.busy      = (state_q == READ) || (state_q == SEND);
    bus.done      = (state_q == DONE);
    bus.out_valid = (state_q == SEND);
    bus.rf_addr   = idx_q;
    bus.out_data  = data_q;
    bus.out_index = oidx_q;
  end

endmodule
